// File: rtl/berger_code_scrubber.sv
// Berger-code memory scrubber.
// Sweeps addresses 0..DEPTH-1 of a Berger-coded memory, two cycles per word
// (ISSUE drives the address, CHECK samples the decoder's error flag on its
// closing edge). Host writes are muxed onto the memory port in every state
// except CHECK, so a sweep read and a host write never touch the port in the
// same cycle. A granted host write re-encodes the word, so its error-bitmap
// bit is cleared; the error count and first-error address keep the history
// of the sweep.
module berger_code_scrubber #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              host_wr_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_err,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic [DEPTH-1:0]  err_bitmap,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] first_next;
    logic [DEPTH-1:0]  bitmap_reg;

    logic grant;
    logic sweep_start;
    logic check_err;
    logic last_addr;

    // The grant is gated by reset so that the combinational handshake and
    // memory-port outputs are all forced low while rst is asserted.
    assign grant       = rst && host_wr_req && (state_reg != CHECK);
    assign sweep_start = (state_reg == IDLE) && start;
    assign check_err   = (state_reg == CHECK) && mem_err;
    assign last_addr   = (addr_reg == ADDR_W'(DEPTH - 1));

    // State, sweep address and error summary registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            count_reg <= '0;
            first_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            count_reg <= count_next;
            first_reg <= first_next;
        end
    end

    // Next-state logic: sweep sequencing, error counting and first-error capture.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        count_next = count_reg;
        first_next = first_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                    addr_next  = '0;
                    count_next = '0;
                    first_next = '0;
                end
            end
            ISSUE: begin
                // A granted host write owns the port this cycle; retry the read.
                if (!grant) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (mem_err) begin
                    count_next = count_reg + (ADDR_W + 1)'(1);
                    // Host writes never touch the count, so a zero count means
                    // no error has been seen yet in this sweep.
                    if (count_reg == '0) begin
                        first_next = addr_reg;
                    end
                end
                if (last_addr) begin
                    state_next = DONE;
                end else begin
                    addr_next  = addr_reg + ADDR_W'(1);
                    state_next = ISSUE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory-port mux: host write when granted, otherwise the sweep address.
    always_comb begin
        host_wr_ack = grant;
        mem_wr_en   = grant;
        mem_wr_data = '0;
        mem_addr    = '0;
        if (grant) begin
            mem_addr    = host_addr;
            mem_wr_data = host_data;
        end else if ((state_reg == ISSUE) || (state_reg == CHECK)) begin
            mem_addr = addr_reg;
        end
    end

    // One flop per memory word: set by a failed check, cleared by a fresh
    // host write or at the start of a new sweep.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bitmap
            logic flag_reg;
            logic hit;
            logic scrub;

            assign hit   = check_err && (addr_reg == ADDR_W'(gi));
            assign scrub = grant && (host_addr == ADDR_W'(gi));

            // Per-word error flag.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    flag_reg <= 1'b0;
                end else if (sweep_start) begin
                    flag_reg <= 1'b0;
                end else if (hit) begin
                    flag_reg <= 1'b1;
                end else if (scrub) begin
                    flag_reg <= 1'b0;
                end
            end

            assign bitmap_reg[gi] = flag_reg;
        end
    endgenerate

    assign busy           = (state_reg != IDLE);
    assign done           = (state_reg == DONE);
    assign err_count      = count_reg;
    assign err_bitmap     = bitmap_reg;
    assign first_err_addr = first_reg;

endmodule

// File: tb/tb_berger_code_scrubber.sv
// Directed testbench for berger_code_scrubber (DEPTH=16, ADDR_W=4, DATA_W=8).
module tb_berger_code_scrubber;

    logic        clk;
    logic        rst;
    logic        start;
    logic        host_wr_req;
    logic [3:0]  host_addr;
    logic [7:0]  host_data;
    logic        host_wr_ack;
    logic [3:0]  mem_addr;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_data;
    logic        mem_err;
    logic        busy;
    logic        done;
    logic [4:0]  err_count;
    logic [15:0] err_bitmap;
    logic [3:0]  first_err_addr;

    logic        inject_en;
    int          tests;
    int          fails;
    int          cyc;
    int          done_at;
    int          busy_n;
    logic [3:0]  first_addr;
    bit          saw_done;

    berger_code_scrubber #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .host_wr_req    (host_wr_req),
        .host_addr      (host_addr),
        .host_data      (host_data),
        .host_wr_ack    (host_wr_ack),
        .mem_addr       (mem_addr),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .mem_err        (mem_err),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .err_bitmap     (err_bitmap),
        .first_err_addr (first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: words 5 and 12 are corrupted when injection is enabled.
    assign mem_err = inject_en && !mem_wr_en && ((mem_addr == 4'd5) || (mem_addr == 4'd12));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulse start, then follow the sweep until done (bounded). Optionally
    // raise start mid-sweep and again during the DONE cycle.
    task automatic run_sweep(input bit poke_start, output int d_at, output int b_n,
                             output logic [3:0] f_addr);
        d_at   = -1;
        b_n    = 0;
        f_addr = 4'hx;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        for (int i = 0; i < 80 && d_at < 0; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 0) f_addr = mem_addr;
            if (done) d_at = i;
            else if (busy) b_n++;
            start = poke_start && ((i == 5) || done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        cyc         = 0;
        rst         = 1'b0;
        start       = 1'b0;
        host_wr_req = 1'b0;
        host_addr   = 4'd0;
        host_data   = 8'd0;
        inject_en   = 1'b0;

        // ---- reset state (host request must not leak through reset) ----
        #3;
        host_wr_req = 1'b1;
        host_addr   = 4'd9;
        host_data   = 8'h77;
        #1;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_ack",    32'(host_wr_ack), 32'd0);
        check("rst_wr_en",  32'(mem_wr_en), 32'd0);
        check("rst_addr",   32'(mem_addr), 32'd0);
        check("rst_wdata",  32'(mem_wr_data), 32'd0);
        check("rst_count",  32'(err_count), 32'd0);
        check("rst_bitmap", 32'(err_bitmap), 32'd0);
        check("rst_first",  32'(first_err_addr), 32'd0);
        host_wr_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ---- clean sweep ----
        run_sweep(1'b0, done_at, busy_n, first_addr);
        $display("[TB] clean sweep: done_at=%0d busy_cycles=%0d", done_at, busy_n);
        check("clean_done_cycle", 32'(done_at), 32'd32);
        check("clean_busy_cycles", 32'(busy_n), 32'd32);
        check("clean_first_addr", 32'(first_addr), 32'd0);
        check("clean_idle_busy", 32'(busy), 32'd0);
        check("clean_idle_done", 32'(done), 32'd0);
        check("clean_count", 32'(err_count), 32'd0);
        check("clean_bitmap", 32'(err_bitmap), 32'd0);

        // ---- errors at 5 and 12, start poked while busy and in DONE ----
        inject_en = 1'b1;
        run_sweep(1'b1, done_at, busy_n, first_addr);
        inject_en = 1'b0;
        $display("[TB] error sweep: done_at=%0d count=%0d bitmap=%h first=%0d",
                 done_at, err_count, err_bitmap, first_err_addr);
        check("err_done_cycle", 32'(done_at), 32'd32);
        check("err_start_in_done_ignored", 32'(busy), 32'd0);
        check("err_count", 32'(err_count), 32'd2);
        check("err_bitmap", 32'(err_bitmap), 32'h1020);
        check("err_first", 32'(first_err_addr), 32'd5);
        repeat (3) tick();
        check("idle_stable_count", 32'(err_count), 32'd2);
        check("idle_stable_bitmap", 32'(err_bitmap), 32'h1020);
        check("idle_stable_first", 32'(first_err_addr), 32'd5);

        // ---- host write to flagged address 12 while idle ----
        host_wr_req = 1'b1;
        host_addr   = 4'd12;
        host_data   = 8'hA5;
        #1;
        $display("[TB] host write idle: ack=%0d addr=%0d data=%h", host_wr_ack, mem_addr, mem_wr_data);
        check("idle_wr_ack", 32'(host_wr_ack), 32'd1);
        check("idle_wr_en", 32'(mem_wr_en), 32'd1);
        check("idle_wr_addr", 32'(mem_addr), 32'd12);
        check("idle_wr_data", 32'(mem_wr_data), 32'hA5);
        tick();
        host_wr_req = 1'b0;
        #1;
        check("scrub_bitmap", 32'(err_bitmap), 32'h0020);
        check("scrub_count", 32'(err_count), 32'd2);
        check("scrub_first", 32'(first_err_addr), 32'd5);
        check("scrub_wdata_zero", 32'(mem_wr_data), 32'd0);

        // ---- host writes during a sweep: ISSUE (same-cycle ack) and CHECK ----
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        repeat (6) tick();
        check("issue3_addr", 32'(mem_addr), 32'd3);
        host_wr_req = 1'b1;
        host_addr   = 4'd3;
        host_data   = 8'h3C;
        #1;
        $display("[TB] host write in ISSUE: ack=%0d wr_en=%0d addr=%0d", host_wr_ack, mem_wr_en, mem_addr);
        check("issue_ack", 32'(host_wr_ack), 32'd1);
        check("issue_wr_en", 32'(mem_wr_en), 32'd1);
        check("issue_wr_data", 32'(mem_wr_data), 32'h3C);
        tick();
        host_wr_req = 1'b0;
        #1;
        check("stall_addr", 32'(mem_addr), 32'd3);
        check("stall_wr_en", 32'(mem_wr_en), 32'd0);
        tick();
        host_wr_req = 1'b1;
        host_addr   = 4'd9;
        host_data   = 8'h5A;
        #1;
        $display("[TB] host write in CHECK: ack=%0d addr=%0d", host_wr_ack, mem_addr);
        check("check_no_ack", 32'(host_wr_ack), 32'd0);
        check("check_no_wr", 32'(mem_wr_en), 32'd0);
        check("check_addr_held", 32'(mem_addr), 32'd3);
        tick();
        check("late_ack", 32'(host_wr_ack), 32'd1);
        check("late_addr", 32'(mem_addr), 32'd9);
        tick();
        host_wr_req = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 80 && !saw_done; k++) begin
            if (done) saw_done = 1'b1;
            else tick();
        end
        $display("[TB] stalled sweep done at cycle %0d", cyc);
        check("stalled_done_seen", 32'(saw_done), 32'd1);
        check("stalled_done_cycle", 32'(cyc), 32'd34);
        tick();

        // ---- reset in CHECK at address 7 ----
        inject_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        repeat (15) tick();
        check("pre_rst_addr", 32'(mem_addr), 32'd7);
        check("pre_rst_count", 32'(err_count), 32'd1);
        rst = 1'b0;
        host_wr_req = 1'b1;
        host_addr   = 4'd2;
        host_data   = 8'hFF;
        #1;
        $display("[TB] reset mid-sweep: busy=%0d count=%0d bitmap=%h", busy, err_count, err_bitmap);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ack", 32'(host_wr_ack), 32'd0);
        check("abort_wr_en", 32'(mem_wr_en), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_count", 32'(err_count), 32'd0);
        check("abort_bitmap", 32'(err_bitmap), 32'd0);
        check("abort_first", 32'(first_err_addr), 32'd0);
        tick();
        check("abort_no_done", 32'(done), 32'd0);
        host_wr_req = 1'b0;
        inject_en   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_no_done", 32'(done), 32'd0);
        run_sweep(1'b0, done_at, busy_n, first_addr);
        $display("[TB] restart sweep: first_addr=%0d done_at=%0d", first_addr, done_at);
        check("restart_addr0", 32'(first_addr), 32'd0);
        check("restart_done_cycle", 32'(done_at), 32'd32);
        check("restart_count", 32'(err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
